// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a program write port and a fixed-latency fetch FSM feeding the cpu ins port.
// Optional one-entry next-word prefetch buffer enabled by defining IMEM_PREFETCH_EN.
module instr_mem_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_ram_in,
    input  logic [15:0]       addr,
    output logic [DATA_W-1:0] ins,
    output logic              en_ram_out,
    output logic              err,
    output logic              busy,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WAIT_CYC = (RD_LAT > 1) ? (RD_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] ins_q, ins_d;
    logic              en_out_q, en_out_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              in_range_c;
    logic [ADDR_W-1:0] idx_c;

`ifdef IMEM_PREFETCH_EN
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pf_valid_q, pf_valid_d;
    logic [ADDR_W-1:0] pf_tag_q, pf_tag_d;
    logic [DATA_W-1:0] pf_data_q, pf_data_d;
    logic              pf_hit_c;
`endif

    assign idx_c      = addr[ADDR_W-1:0];
    assign in_range_c = ((addr >> ADDR_W) == 16'd0);

`ifdef IMEM_PREFETCH_EN
    assign pf_hit_c = in_range_c && pf_valid_q && (idx_c == pf_tag_q);
`endif

    assign ins        = ins_q;
    assign en_ram_out = en_out_q;
    assign err        = err_q;
    assign busy       = busy_q;

    // Program port: never stalled, no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            oor_q      <= 1'b0;
            data_q     <= '0;
            ins_q      <= '0;
            en_out_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef IMEM_PREFETCH_EN
            addr_q     <= '0;
            pf_valid_q <= 1'b0;
            pf_tag_q   <= '0;
            pf_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            oor_q      <= oor_d;
            data_q     <= data_d;
            ins_q      <= ins_d;
            en_out_q   <= en_out_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
`ifdef IMEM_PREFETCH_EN
            addr_q     <= addr_d;
            pf_valid_q <= pf_valid_d;
            pf_tag_q   <= pf_tag_d;
            pf_data_q  <= pf_data_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        oor_d      = oor_q;
        data_d     = data_q;
        ins_d      = ins_q;
        en_out_d   = 1'b0;
        err_d      = 1'b0;
`ifdef IMEM_PREFETCH_EN
        addr_d     = addr_q;
        pf_valid_d = pf_valid_q;
        pf_tag_d   = pf_tag_q;
        pf_data_d  = pf_data_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (en_ram_in) begin
                    // Array is read on the accept edge, so a same-edge write returns the old word.
                    oor_d   = ~in_range_c;
                    data_d  = mem[idx_c];
                    cnt_d   = '0;
                    state_d = (RD_LAT == 1) ? S_RESP : S_WAIT;
`ifdef IMEM_PREFETCH_EN
                    addr_d  = idx_c;
                    if (pf_hit_c) begin
                        data_d  = pf_data_q;
                        state_d = S_RESP;
                    end else begin
                        pf_valid_d = 1'b0;
                    end
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            S_RESP: begin
                state_d  = S_IDLE;
                en_out_d = 1'b1;
                err_d    = oor_q;
                ins_d    = oor_q ? '0 : data_q;
`ifdef IMEM_PREFETCH_EN
                if (!oor_q) begin
                    pf_tag_d   = ADDR_W'(addr_q + 1'b1);
                    pf_data_d  = mem[ADDR_W'(addr_q + 1'b1)];
                    pf_valid_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef IMEM_PREFETCH_EN
        // Any write to the buffered address (including one on the fill edge) makes it stale.
        if (prog_we && (prog_addr == pf_tag_d)) begin
            pf_valid_d = 1'b0;
        end
`endif

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: stimulus pushes expected responses, a monitor pops on en_ram_out.
module tb_instr_mem_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RD_LAT = 2;

    typedef struct {
        logic [15:0] ins;
        logic        err;
        int unsigned cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en_ram_in = 1'b0;
    logic [15:0]       addr = 16'd0;
    logic [DATA_W-1:0] ins;
    logic              en_ram_out;
    logic              err;
    logic              busy;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [DATA_W-1:0] prog_data = '0;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] shadow [256];
    bit          pf_valid = 1'b0;
    logic [7:0]  pf_tag = 8'd0;
    logic [7:0]  last_a = 8'd0;

    instr_mem_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_ram_in (en_ram_in),
        .addr      (addr),
        .ins       (ins),
        .en_ram_out(en_ram_out),
        .err       (err),
        .busy      (busy),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (en_ram_out === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: cyc=%0d ins=%h err=%b", cyc, ins, err);
                end else begin
                    mon_e = q.pop_front();
                    if (ins !== mon_e.ins || err !== mon_e.err || cyc != mon_e.cyc) begin
                        bad++;
                        $display("FAIL fetch_resp: got ins=%h err=%b cyc=%0d want ins=%h err=%b cyc=%0d",
                                 ins, err, cyc, mon_e.ins, mon_e.err, mon_e.cyc);
                    end
                end
            end else begin
                total++;
                if (en_ram_out !== 1'b0 || err !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_outputs: en_ram_out=%b err=%b want 0 0 cyc=%0d", en_ram_out, err, cyc);
                end
            end
        end
    end

    task automatic write_word(input logic [7:0] a, input logic [15:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        shadow[a] = d;
        if (a == pf_tag) pf_valid = 1'b0;
    endtask

    // One fetch: expectation from the shadow memory as it stood before the accept edge.
    task automatic fetch(input logic [15:0] a, input bit hold, input bit cw,
                         input logic [7:0] wa, input logic [15:0] wd);
        exp_t        e;
        bit          inr;
        bit          hit;
        int unsigned lat;
        inr = (a[15:8] == 8'd0);
`ifdef IMEM_PREFETCH_EN
        hit = inr && pf_valid && (a[7:0] == pf_tag);
`else
        hit = 1'b0;
`endif
        lat = hit ? 1 : RD_LAT;
        e.ins = inr ? shadow[a[7:0]] : 16'h0000;
        e.err = ~inr;
        en_ram_in = 1'b1;
        addr = a;
        if (cw) begin
            prog_we = 1'b1;
            prog_addr = wa;
            prog_data = wd;
        end
        @(posedge clk);
        #1;
        e.cyc = cyc + lat;
        q.push_back(e);
        prog_we = 1'b0;
        if (!hold) begin
            en_ram_in = 1'b0;
            addr = 16'($urandom);
        end
        if (!hit) pf_valid = 1'b0;
        if (cw) begin
            shadow[wa] = wd;
            if (wa == pf_tag) pf_valid = 1'b0;
        end
        repeat (lat) @(posedge clk);
        #1;
        if (inr) begin
            pf_tag = 8'(a[7:0] + 8'd1);
            pf_valid = 1'b1;
        end
        last_a = a[7:0];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [15:0] a;
        logic [7:0]  wa;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ins", 32'(ins), 32'h0);
        chk("reset_en_ram_out", 32'(en_ram_out), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 256; i++) write_word(8'(i), 16'($urandom));

        // Basic fetch, then out of range.
        write_word(8'd1, 16'h0001);
        fetch(16'd1, 1'b0, 1'b0, 8'd0, 16'd0);
        fetch(16'h0400, 1'b0, 1'b0, 8'd0, 16'd0);

        // Write and accept to the same address on one edge.
        write_word(8'd2, 16'hAFC2);
        fetch(16'd2, 1'b0, 1'b1, 8'd2, 16'h0402);
        fetch(16'd2, 1'b0, 1'b0, 8'd0, 16'd0);

        // Reset during WAIT aborts the fetch.
        en_ram_in = 1'b1;
        addr = 16'd3;
        @(posedge clk);
        #1;
        en_ram_in = 1'b0;
        chk("busy_in_fetch", 32'(busy), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pf_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ins", 32'(ins), 32'h0);
        chk("abort_en_ram_out", 32'(en_ram_out), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        fetch(16'd3, 1'b0, 1'b0, 8'd0, 16'd0);

        // Held request: back-to-back fetches.
        for (int i = 0; i < 4; i++) fetch(16'd1, 1'b1, 1'b0, 8'd0, 16'd0);
        en_ram_in = 1'b0;

        // Sequential fetches, with and without an intervening write; top-address wrap.
        fetch(16'd5, 1'b0, 1'b0, 8'd0, 16'd0);
        fetch(16'd6, 1'b0, 1'b0, 8'd0, 16'd0);
        fetch(16'd5, 1'b0, 1'b0, 8'd0, 16'd0);
        write_word(8'd6, 16'h1234);
        fetch(16'd6, 1'b0, 1'b0, 8'd0, 16'd0);
        fetch(16'd255, 1'b0, 1'b0, 8'd0, 16'd0);
        fetch(16'd0, 1'b0, 1'b0, 8'd0, 16'd0);

        // Randomized mix.
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) a = 16'($urandom) | 16'h0100;
            else if (r < 5) a = {8'd0, 8'(last_a + 8'd1)};
            else a = {8'd0, 8'($urandom)};
            if ($urandom_range(0, 9) < 3) begin
                wa = ($urandom_range(0, 1) == 1) ? pf_tag : 8'($urandom);
                write_word(wa, 16'($urandom));
            end
            if ($urandom_range(0, 9) < 3) begin
                wa = ($urandom_range(0, 1) == 1) ? a[7:0] : pf_tag;
                fetch(a, 1'b0, 1'b1, wa, 16'($urandom));
            end else begin
                fetch(a, 1'b0, 1'b0, 8'd0, 16'd0);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
